// File: rtl/aud_pkg.sv
// ---------------------------------------------------------------------------
// aud_pkg
// Shared widths and the player state encoding for the SRAM-to-codec audio
// player.
//   AUD_DW      : sample word width (bits shifted per LRC-high phase)
//   AUD_AW      : SRAM word address width
//   aud_state_e : player states
// ---------------------------------------------------------------------------
package aud_pkg;

  localparam int AUD_DW = 16;
  localparam int AUD_AW = 20;

  typedef enum logic [2:0] {
    IDLE,   // not playing, address parked at 0
    WAIT,   // waiting for the next LRC rise
    SHIFT,  // serialising one word
    GAP,    // word done, waiting for LRC to drop before re-arming
    PAUSE   // playback suspended, address held
  } aud_state_e;

endpackage

// File: rtl/aud_player_if.sv
// ---------------------------------------------------------------------------
// aud_player_if
// Control, codec and SRAM signals of the audio player, bundled.
//   i_daclrck   : codec DAC LR clock (transmit while high)
//   i_start     : start / resume (level)
//   i_pause     : pause request
//   i_stop      : abort playback
//   i_end_addr  : last SRAM word to play, inclusive
//   i_sram_data : SRAM read data for o_sram_addr (same cycle)
//   o_sram_addr : SRAM word address
//   o_aud_dacdat: serial data to the codec
//   o_playing   : high in WAIT, SHIFT and GAP
//   o_done      : one-cycle pulse when the final word finishes
// Modports: master = controller/codec/SRAM side, slave = the player.
// ---------------------------------------------------------------------------
interface aud_player_if;
  import aud_pkg::*;

  logic              i_daclrck;
  logic              i_start;
  logic              i_pause;
  logic              i_stop;
  logic [AUD_AW-1:0] i_end_addr;
  logic [AUD_DW-1:0] i_sram_data;
  logic [AUD_AW-1:0] o_sram_addr;
  logic              o_aud_dacdat;
  logic              o_playing;
  logic              o_done;

  modport master (
    output i_daclrck, i_start, i_pause, i_stop, i_end_addr, i_sram_data,
    input  o_sram_addr, o_aud_dacdat, o_playing, o_done
  );

  modport slave (
    input  i_daclrck, i_start, i_pause, i_stop, i_end_addr, i_sram_data,
    output o_sram_addr, o_aud_dacdat, o_playing, o_done
  );

endinterface

// File: rtl/aud_tx_shifter.sv
// ---------------------------------------------------------------------------
// aud_tx_shifter
// Parallel-load, MSB-first serialiser with a bit counter.
//   clk, rst : bit clock, asynchronous active-high reset
//   load     : capture data; its MSB is presented right after this edge
//   abort    : drop the current word immediately
//   data     : parallel word
//   busy     : a word is being presented
//   last     : the LSB is currently presented (word finishes on next edge)
//   msb      : current bit (only meaningful while busy)
// ---------------------------------------------------------------------------
module aud_tx_shifter
  import aud_pkg::*;
#(
  parameter int DATA_W = AUD_DW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              abort,
  input  logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              last,
  output logic              msb
);

  localparam int CNT_W = $clog2(DATA_W);

  logic [DATA_W-1:0] sreg;
  logic [CNT_W-1:0]  cnt;

  assign last = busy && (cnt == CNT_W'(DATA_W - 1));
  assign msb  = sreg[DATA_W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (abort) begin
      sreg <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (load) begin
      sreg <= data;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      if (last) begin
        sreg <= '0;
        cnt  <= '0;
        busy <= 1'b0;
      end else begin
        sreg <= sreg << 1;
        cnt  <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/aud_player.sv
// ---------------------------------------------------------------------------
// aud_player
// Streams 16-bit words from SRAM address 0..end_addr to a codec DAC, one word
// per LRC-high phase, MSB first, starting on the BCLK edge that sees LRC rise.
//   i_clk : codec bit clock (BCLK), all logic on posedge
//   i_rst : asynchronous active-high reset
//   bus   : aud_player_if.slave (control, codec and SRAM signals)
// Build option: define AUD_PLAYER_LOOP_EN to replay continuously; the final
// word still pulses o_done and rewinds the address, but playback carries on
// via GAP instead of returning to IDLE.
// ---------------------------------------------------------------------------
module aud_player
  import aud_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  aud_player_if.slave  bus
);

  aud_state_e        state, state_n;
  logic [AUD_AW-1:0] addr, addr_n;
  logic [AUD_AW-1:0] end_lat;
  logic              done_q, done_n;
  logic              pend, pend_n;   // pause seen mid-word, applied at word end
  logic              lrc_prev;
  logic              lrc_rise;
  logic              load, abort, latch_end;
  logic              busy, last, msb;
  logic              pause_now;

  assign lrc_rise  = bus.i_daclrck && !lrc_prev;
  assign pause_now = pend || bus.i_pause;

  aud_tx_shifter #(.DATA_W(AUD_DW)) u_shift (
    .clk   (i_clk),
    .rst   (i_rst),
    .load  (load),
    .abort (abort),
    .data  (bus.i_sram_data),
    .busy  (busy),
    .last  (last),
    .msb   (msb)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      addr     <= '0;
      done_q   <= 1'b0;
      pend     <= 1'b0;
      lrc_prev <= 1'b0;
    end else begin
      state    <= state_n;
      addr     <= addr_n;
      done_q   <= done_n;
      pend     <= pend_n;
      lrc_prev <= bus.i_daclrck;
    end
  end

  // End address is a data latch; it is only compared after a start.
  always_ff @(posedge i_clk) begin
    if (latch_end) end_lat <= bus.i_end_addr;
  end

  always_comb begin
    state_n   = state;
    addr_n    = addr;
    done_n    = 1'b0;
    pend_n    = pend;
    load      = 1'b0;
    abort     = 1'b0;
    latch_end = 1'b0;
    if (bus.i_stop) begin
      state_n = IDLE;
      addr_n  = '0;
      pend_n  = 1'b0;
      abort   = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (!bus.i_pause && bus.i_start) begin
            state_n   = WAIT;
            addr_n    = '0;
            latch_end = 1'b1;
          end
        end
        WAIT: begin
          if (bus.i_pause) begin
            state_n = PAUSE;
          end else if (lrc_rise) begin
            state_n = SHIFT;
            load    = 1'b1;
          end
        end
        SHIFT: begin
          if (bus.i_pause) pend_n = 1'b1;
          if (last) begin
            pend_n = 1'b0;
            if (addr == end_lat) begin
              done_n = 1'b1;
              addr_n = '0;
`ifdef AUD_PLAYER_LOOP_EN
              state_n = pause_now ? PAUSE : GAP;
`else
              state_n = IDLE;
`endif
            end else begin
              addr_n  = addr + AUD_AW'(1);
              state_n = pause_now ? PAUSE : GAP;
            end
          end
        end
        GAP: begin
          if (bus.i_pause) begin
            state_n = PAUSE;
          end else if (!bus.i_daclrck) begin
            state_n = WAIT;
          end
        end
        PAUSE: begin
          if (!bus.i_pause && bus.i_start) state_n = WAIT;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.o_sram_addr  = addr;
  assign bus.o_aud_dacdat = busy && msb;
  assign bus.o_playing    = (state == WAIT) || (state == SHIFT) || (state == GAP);
  assign bus.o_done       = done_q;

endmodule
